// File: rtl/retire_commit.sv
// In-order retirement: aRAT update, free-list return, flush restore sequencing.
// Optional COMMIT_PERF_CNT_EN adds saturating retire/flush counters.
module retire_commit #(
  parameter int PREG_W   = 5,
  parameter int FL_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            cm_valid,
  output logic                  cm_ready,
  input  logic [3:0]            cm_wen,
  input  logic [3:0]            cm_flush,
  input  logic [4:0]            cm_adst0,
  input  logic [4:0]            cm_adst1,
  input  logic [4:0]            cm_adst2,
  input  logic [4:0]            cm_adst3,
  input  logic [PREG_W-1:0]     cm_pdst0,
  input  logic [PREG_W-1:0]     cm_pdst1,
  input  logic [PREG_W-1:0]     cm_pdst2,
  input  logic [PREG_W-1:0]     cm_pdst3,
  input  logic [PREG_W-1:0]     cm_opdst0,
  input  logic [PREG_W-1:0]     cm_opdst1,
  input  logic [PREG_W-1:0]     cm_opdst2,
  input  logic [PREG_W-1:0]     cm_opdst3,
  input  logic [6:0]            fl_count,
  output logic [PREG_W-1:0]     fl_data0,
  output logic [PREG_W-1:0]     fl_data1,
  output logic [PREG_W-1:0]     fl_data2,
  output logic [PREG_W-1:0]     fl_data3,
  output logic [2:0]            fl_wen,
  output logic                  restore_en,
  output logic [32*PREG_W-1:0]  aRAT_value,
  output logic                  flush_req,
  input  logic                  flush_ack,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_flushes
);

  typedef enum logic [1:0] {
    S_RUN,
    S_RESTORE,
    S_WAIT
  } state_t;

  state_t state;

  logic [4:0]        adst  [4];
  logic [PREG_W-1:0] pdst  [4];
  logic [PREG_W-1:0] opdst [4];
  logic [PREG_W-1:0] arat  [32];
  logic [PREG_W-1:0] fdat  [4];
  logic [PREG_W-1:0] fq    [4];

  logic [3:0] eff;
  logic [3:0] wr;
  logic       blk;
  logic       any_flush;
  logic       accept;
  logic [2:0] nfree;
  logic [2:0] neff;

  assign adst[0]  = cm_adst0;
  assign adst[1]  = cm_adst1;
  assign adst[2]  = cm_adst2;
  assign adst[3]  = cm_adst3;
  assign pdst[0]  = cm_pdst0;
  assign pdst[1]  = cm_pdst1;
  assign pdst[2]  = cm_pdst2;
  assign pdst[3]  = cm_pdst3;
  assign opdst[0] = cm_opdst0;
  assign opdst[1] = cm_opdst1;
  assign opdst[2] = cm_opdst2;
  assign opdst[3] = cm_opdst3;

  assign cm_ready = resetn
                  & (state == S_RUN)
                  & ({1'b0, fl_count} <= 8'(FL_DEPTH - 4));
  assign accept   = cm_ready & cm_valid[0];

  // Slots above the first flushing slot are squashed.
  always_comb begin
    blk   = 1'b0;
    eff   = '0;
    wr    = '0;
    nfree = '0;
    neff  = '0;
    for (int k = 0; k < 4; k++) begin
      fdat[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      eff[k] = cm_valid[k] & ~blk;
      blk    = blk | (cm_valid[k] & cm_flush[k]);
      wr[k]  = eff[k] & cm_wen[k] & (adst[k] != 5'd0);
      neff   = neff + {2'b0, eff[k]};
      if (wr[k]) begin
        fdat[nfree[1:0]] = opdst[k];
        nfree            = nfree + 3'd1;
      end
    end
  end

  assign any_flush = |(eff & cm_flush);

  // Later slots override earlier ones: intra-group WAW.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        arat[i] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (wr[k]) begin
          arat[adst[k]] <= pdst[k];
        end
      end
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_pack
    assign aRAT_value[(32-i)*PREG_W-1 -: PREG_W] = arat[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_RUN;
      restore_en <= 1'b0;
      flush_req  <= 1'b0;
      fl_wen     <= '0;
      for (int k = 0; k < 4; k++) begin
        fq[k] <= '0;
      end
    end else begin
      restore_en <= 1'b0;
      fl_wen     <= accept ? nfree : 3'd0;
      for (int k = 0; k < 4; k++) begin
        fq[k] <= accept ? fdat[k] : '0;
      end
      unique case (state)
        S_RUN: begin
          if (accept && any_flush) begin
            state      <= S_RESTORE;
            restore_en <= 1'b1;
            flush_req  <= 1'b1;
          end
        end
        S_RESTORE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush_ack) begin
            state     <= S_RUN;
            flush_req <= 1'b0;
          end
        end
        default: begin
          state     <= S_RUN;
          flush_req <= 1'b0;
        end
      endcase
    end
  end

  assign fl_data0 = fq[0];
  assign fl_data1 = fq[1];
  assign fl_data2 = fq[2];
  assign fl_data3 = fq[3];

`ifdef COMMIT_PERF_CNT_EN
  logic [32:0] ret_sum;
  assign ret_sum = {1'b0, perf_retired} + {30'b0, neff};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      if (accept) begin
        perf_retired <= ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
      end
      if (accept && any_flush && (perf_flushes != 32'hFFFF_FFFF)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf  = ^neff;
  assign perf_retired = '0;
  assign perf_flushes = '0;
`endif

endmodule
